line_burst_arbiter: RTL

LINE_BURST_ARBITER -- requirements
Module: line_burst_arbiter

---
 rtl/line_burst_arbiter.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/line_burst_arbiter.sv
// Round-robin arbiter that turns per-channel cache-line read/write requests
// into single-outstanding DRAM bursts of LINE_W/BUS_W beats.
module line_burst_arbiter #(
  parameter int unsigned NUM_CH = 2,
  parameter int unsigned LINE_W = 256,
  parameter int unsigned BUS_W  = 64
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_CH*32-1:0]       ch_addr,
  input  logic [NUM_CH-1:0]          ch_read,
  input  logic [NUM_CH-1:0]          ch_write,
  input  logic [NUM_CH*LINE_W-1:0]   ch_wdata,
  output logic [LINE_W-1:0]          ch_rdata,
  output logic [NUM_CH-1:0]          ch_resp,
  output logic [31:0]                dram_addr,
  output logic                       dram_read,
  output logic                       dram_write,
  output logic [BUS_W-1:0]           dram_wdata,
  input  logic                       dram_ready,
  input  logic [31:0]                dram_raddr,
  input  logic [BUS_W-1:0]           dram_rdata,
  input  logic                       dram_rvalid
);

  localparam int unsigned BEATS      = LINE_W / BUS_W;
  localparam int unsigned BEAT_W     = $clog2(BEATS);
  localparam int unsigned CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [31:0] ALIGN_MASK = ~(32'(LINE_W / 8) - 32'd1);

  typedef enum logic [2:0] {IDLE, RD_REQ, RD_DATA, WR_BURST, RESP} state_t;

  state_t                        state_q, state_n;
  logic [BEAT_W-1:0]             beat_q, beat_n;
  logic [CH_W-1:0]               rr_q, rr_n;
  logic [CH_W-1:0]               gnt_q, gnt_n;
  logic [31:0]                   addr_q, addr_n;
  logic [BEATS-1:0][BUS_W-1:0]   line_q, line_n;
  logic [BEATS-1:0][BUS_W-1:0]   rdata_q, rdata_n;

  logic                          dram_read_n, dram_write_n;
  logic [31:0]                   dram_addr_n;
  logic [BUS_W-1:0]              dram_wdata_n;
  logic [NUM_CH-1:0]             ch_resp_n;

  logic [NUM_CH-1:0][31:0]       addr_v;
  logic [NUM_CH-1:0][LINE_W-1:0] wdata_v;
  logic [NUM_CH-1:0]             req;
  logic                          gnt_found;
  logic [CH_W-1:0]               gnt_idx;
  logic [CH_W-1:0]               cand;

  assign addr_v   = ch_addr;
  assign wdata_v  = ch_wdata;
  assign req      = ch_read | ch_write;
  assign ch_rdata = rdata_q;

  // Round-robin search starting at rr_q, first requester wins
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      cand = CH_W'((32'(rr_q) + i) % NUM_CH);
      if (!gnt_found && req[cand]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand;
      end
    end
  end

  // Next-state and next-output logic; outputs are registered from the next state
  always_comb begin
    state_n = state_q;
    beat_n  = beat_q;
    rr_n    = rr_q;
    gnt_n   = gnt_q;
    addr_n  = addr_q;
    line_n  = line_q;
    rdata_n = rdata_q;

    case (state_q)
      IDLE: begin
        if (gnt_found) begin
          gnt_n  = gnt_idx;
          addr_n = addr_v[gnt_idx] & ALIGN_MASK;
          beat_n = '0;
          if (ch_write[gnt_idx]) begin
            line_n  = wdata_v[gnt_idx];
            state_n = WR_BURST;
          end else begin
            state_n = RD_REQ;
          end
        end
      end
      RD_REQ: begin
        if (dram_ready) state_n = RD_DATA;
      end
      RD_DATA: begin
        // Beats tagged with another address belong to someone else
        if (dram_rvalid && (dram_raddr == addr_q)) begin
          rdata_n[beat_q] = dram_rdata;
          beat_n          = beat_q + 1'b1;
          if (beat_q == BEAT_W'(BEATS - 1)) state_n = RESP;
        end
      end
      WR_BURST: begin
        if (dram_ready) begin
          beat_n = beat_q + 1'b1;
          if (beat_q == BEAT_W'(BEATS - 1)) state_n = RESP;
        end
      end
      RESP: begin
        rr_n    = (gnt_q == CH_W'(NUM_CH - 1)) ? '0 : gnt_q + 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase

    dram_read_n  = (state_n == RD_REQ);
    dram_write_n = (state_n == WR_BURST);
    dram_addr_n  = (dram_read_n || dram_write_n) ? addr_n : '0;
    dram_wdata_n = dram_write_n ? line_n[beat_n] : '0;
    ch_resp_n    = '0;
    if (state_n == RESP) ch_resp_n[gnt_n] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      beat_q     <= '0;
      rr_q       <= '0;
      gnt_q      <= '0;
      addr_q     <= '0;
      line_q     <= '0;
      rdata_q    <= '0;
      dram_read  <= 1'b0;
      dram_write <= 1'b0;
      dram_addr  <= '0;
      dram_wdata <= '0;
      ch_resp    <= '0;
    end else begin
      state_q    <= state_n;
      beat_q     <= beat_n;
      rr_q       <= rr_n;
      gnt_q      <= gnt_n;
      addr_q     <= addr_n;
      line_q     <= line_n;
      rdata_q    <= rdata_n;
      dram_read  <= dram_read_n;
      dram_write <= dram_write_n;
      dram_addr  <= dram_addr_n;
      dram_wdata <= dram_wdata_n;
      ch_resp    <= ch_resp_n;
    end
  end

endmodule
